// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the chunked CLA add/subtract sequencer.
// Optional signed-overflow output is enabled with the CLA_SEQ_OVF_EN macro (see cla_wide_add_seq).
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/cla_wide_add_seq_cla_p.sv
// ADDER_SIZE-bit carry-lookahead slice: lookahead inside each GROUP_SIZE group and
// a second lookahead level across the group generate/propagate terms.
module CLA_p #(
  parameter int ADDER_SIZE = 16,
  parameter int GROUP_SIZE = 4
) (
  input  logic [ADDER_SIZE-1:0] a,
  input  logic [ADDER_SIZE-1:0] b,
  input  logic                  cin,
  output logic [ADDER_SIZE-1:0] sum,
  output logic                  cout
);

  localparam int NGROUPS = ADDER_SIZE / GROUP_SIZE;

  logic [ADDER_SIZE-1:0] gen, prop, carry;
  logic [NGROUPS-1:0]    grp_gen, grp_prop;
  logic [NGROUPS:0]      grp_carry;

  // Carry into position k as a flat sum of products of the g/p terms below it.
  function automatic logic carry_into(input logic [ADDER_SIZE-1:0] g,
                                      input logic [ADDER_SIZE-1:0] p,
                                      input int k, input logic c0);
    logic acc, run_p;
    acc   = 1'b0;
    run_p = 1'b1;
    for (int j = ADDER_SIZE - 1; j >= 0; j--) begin
      if (j < k) begin
        acc   = acc | (g[j] & run_p);
        run_p = run_p & p[j];
      end
    end
    return acc | (run_p & c0);
  endfunction

  assign gen  = a & b;
  assign prop = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < NGROUPS; gi++) begin : g_group
      logic [GROUP_SIZE-1:0] g_l, p_l, c_l;

      assign g_l = gen[gi*GROUP_SIZE +: GROUP_SIZE];
      assign p_l = prop[gi*GROUP_SIZE +: GROUP_SIZE];
      assign grp_gen[gi]  = carry_into(ADDER_SIZE'(g_l), ADDER_SIZE'(p_l), GROUP_SIZE, 1'b0);
      assign grp_prop[gi] = &p_l;

      always_comb begin
        c_l = '0;
        for (int k = 0; k < GROUP_SIZE; k++)
          c_l[k] = carry_into(ADDER_SIZE'(g_l), ADDER_SIZE'(p_l), k, grp_carry[gi]);
      end

      assign carry[gi*GROUP_SIZE +: GROUP_SIZE] = c_l;
    end
  endgenerate

  always_comb begin
    grp_carry = '0;
    for (int i = 0; i <= NGROUPS; i++)
      grp_carry[i] = carry_into(ADDER_SIZE'(grp_gen), ADDER_SIZE'(grp_prop), i, cin);
  end

  assign sum  = prop ^ carry;
  assign cout = grp_carry[NGROUPS];

endmodule

// File: rtl/cla_wide_add_seq.sv
// WIDTH-bit add/subtract computed over NBEATS cycles on one shared CLA slice, LSB chunk first.
// Define CLA_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module cla_wide_add_seq
  import cla_seq_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int ADDER_SIZE = 16,
  parameter int GROUP_SIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBEATS = WIDTH / ADDER_SIZE;
  localparam int BEAT_W = (clog2(NBEATS) < 1) ? 1 : clog2(NBEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  generate
    if ((WIDTH % ADDER_SIZE) != 0 || (ADDER_SIZE % GROUP_SIZE) != 0 || NBEATS < 1) begin : g_bad_params
      $error("cla_wide_add_seq: WIDTH must be a multiple of ADDER_SIZE, ADDER_SIZE of GROUP_SIZE");
    end
  endgenerate

  state_t                  state_reg, state_next;
  logic [BEAT_W-1:0]       beat_reg;
  logic                    carry_reg;
  logic [WIDTH-1:0]        a_reg, b_reg, sum_reg;
  logic                    cout_reg;
  logic [ADDER_SIZE-1:0]   slice_a, slice_b, slice_sum;
  logic                    slice_cout;
  logic                    accept, last_beat;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_reg == LAST_BEAT);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

  assign slice_a = a_reg[int'(beat_reg)*ADDER_SIZE +: ADDER_SIZE];
  assign slice_b = b_reg[int'(beat_reg)*ADDER_SIZE +: ADDER_SIZE];

  CLA_p #(
    .ADDER_SIZE (ADDER_SIZE),
    .GROUP_SIZE (GROUP_SIZE)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last_beat) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Subtract is folded into the capture: B is inverted and the +1 rides in as the first carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_reg  <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b ^ {WIDTH{op}};
            carry_reg <= (op == OP_SUB) ? 1'b1 : cin;
            beat_reg  <= '0;
          end
        end
        RUN: begin
          sum_reg[int'(beat_reg)*ADDER_SIZE +: ADDER_SIZE] <= slice_sum;
          carry_reg <= slice_cout;
          if (last_beat) begin
            beat_reg <= '0;
            cout_reg <= slice_cout;
          end else begin
            beat_reg <= beat_reg + BEAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CLA_SEQ_OVF_EN
  logic ovf_reg;
  logic msb_carry_in;

  // Carry into the top bit recovered from the sum bit and its two operand bits.
  assign msb_carry_in = slice_sum[ADDER_SIZE-1] ^ slice_a[ADDER_SIZE-1] ^ slice_b[ADDER_SIZE-1];
  assign ovf          = ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           ovf_reg <= 1'b0;
    else if (state_reg == RUN && last_beat) ovf_reg <= msb_carry_in ^ slice_cout;
  end
`endif

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Table-driven bench for cla_wide_add_seq (64-bit, 16-bit slice) with an expected-result queue.
// Checks ovf as well when CLA_SEQ_OVF_EN is defined.
module tb_cla_wide_add_seq;

  localparam int WIDTH  = 64;
  localparam int NBEATS = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             op = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef CLA_SEQ_OVF_EN
  logic             ovf;
`endif

  always #5 clk = ~clk;

  cla_wide_add_seq #(
    .WIDTH      (64),
    .ADDER_SIZE (16),
    .GROUP_SIZE (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    string            name;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[10];
  vec_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%h want=0x%h", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag);
    vec_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_sum"}, sum, e.exp_sum);
    chk({tag, "_cout"}, 64'(cout), 64'(e.exp_cout));
`ifdef CLA_SEQ_OVF_EN
    chk({tag, "_ovf"}, 64'(ovf), 64'(e.exp_ovf));
`endif
    $display("op %s: op=%0d a=0x%h b=0x%h cin=%0d -> sum=0x%h cout=%0d",
             tag, e.op, e.a, e.b, e.cin, sum, cout);
  endtask

  task automatic drive_accept(input vec_t v);
    @(negedge clk);
    chk({v.name, "_in_ready"}, 64'(in_ready), 64'd1);
    op = v.op; a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
    sb_q.push_back(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(NBEATS));
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_op(input vec_t v);
    drive_accept(v);
    wait_valid(v.name);
    if (!out_valid) begin
      void'(sb_q.pop_front());
      return;
    end
    @(negedge clk);
    check_result(v.name);
    handshake(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    vecs[0] = '{"add_basic",   1'b0, 64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0};
    vecs[1] = '{"add_chain",   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{"sub_borrow",  1'b1, 64'h5, 64'h7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{"add_ovf",     1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{"add_chunks",  1'b0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                64'h0001_0000_0001_0000, 1'b0, 1'b0};
    vecs[5] = '{"sub_pos",     1'b1, 64'h7, 64'h5, 1'b0, 64'h2, 1'b1, 1'b0};
    vecs[6] = '{"sub_ovf",     1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{"sub_cin_ign", 1'b1, 64'd10, 64'd3, 1'b1, 64'd7, 1'b1, 1'b0};
    vecs[8] = '{"add_negovf",  1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[9] = '{"add_allones", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("rst_sum", sum, 64'h0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
`ifdef CLA_SEQ_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Backpressure: hold the result for 10 cycles, with a stray request that must be dropped
    v = '{"backpressure", 1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
          64'h1234_5678_9ABC_DF00, 1'b0, 1'b0};
    drive_accept(v);
    wait_valid(v.name);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_sum", sum, 64'h1234_5678_9ABC_DF00);
      chk("bp_cout", 64'(cout), 64'd0);
      if (i == 3) begin
        op = 1'b0; a = 64'hDEAD; b = 64'hBEEF; cin = 1'b0; in_valid = 1'b1;
      end
      if (i == 4) in_valid = 1'b0;
    end
    @(negedge clk);
    check_result(v.name);
    handshake(v.name);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_no_queue_busy", 64'(busy), 64'd0);
    end
    run_op(vecs[5]);

    // Reset during beat 2 of RUN aborts and clears the partial result
    @(negedge clk);
    op = 1'b0; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    chk("midrst_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_sum", sum, 64'h0);
    chk("midrst_cout", 64'(cout), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
`ifdef CLA_SEQ_OVF_EN
    chk("midrst_ovf", 64'(ovf), 64'd0);
`endif
    $display("op midrst: reset asserted during beat 2, sum=0x%h busy=%0d", sum, busy);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{"after_rst", 1'b0, 64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0};
    run_op(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
